// File: rtl/input_conditioner_if.sv
// Purpose: bundles the raw switch inputs and conditioned outputs of input_conditioner.
// Signals:
//   raw_in      asynchronous raw switch/button levels (driven by the board side)
//   level_out   debounced level per channel
//   rise_pulse  one-cycle strobe on a 0->1 change of level_out
//   fall_pulse  one-cycle strobe on a 1->0 change of level_out
// Modports: master = board/stimulus side, slave = conditioner side.
interface input_conditioner_if #(
  parameter int unsigned WIDTH = 3
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output raw_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  raw_in,
    output level_out,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/input_conditioner.sv
// Purpose: conditions raw board switches/buttons into clean clock-synchronous levels.
//   Per channel: 2-FF synchronizer, counter-based debouncer, one-cycle rise/fall strobes.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  input_conditioner_if.slave: raw_in in; level_out, rise_pulse, fall_pulse out
//        (all outputs registered)
module input_conditioner #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input_conditioner_if.slave  bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [CNT_W-1:0] cnt [WIDTH];

  // Synchronizer plus per-channel debounce; a channel is accepted once the
  // mismatch has persisted with the counter already at its terminal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= bus.raw_in;
      sync2 <= sync1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        if (sync2[i] == level_q[i]) begin
          // Stable or reverted excursion: any partial count is discarded.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          level_q[i] <= sync2[i];
          cnt[i]     <= '0;
          rise_q[i]  <= sync2[i];
          fall_q[i]  <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Purpose: self-checking scoreboard bench for input_conditioner (WIDTH=3, DEBOUNCE_CYCLES=4).
//   Stimulus is applied on falling edges; expected output snapshots are queued with the
//   cycle number at which they must appear and are compared on the falling edge of that cycle.
module tb_input_conditioner;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEB   = 4;

  typedef struct {
    int         cyc;
    logic [2:0] lv;
    logic [2:0] rs;
    logic [2:0] fl;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   both_err;
  int   rise_cnt [WIDTH];
  int   fall_cnt [WIDTH];
  int   exp_rise [WIDTH];
  int   exp_fall [WIDTH];
  exp_t q [$];

  input_conditioner_if #(.WIDTH(WIDTH)) ifc ();

  input_conditioner #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int c, input logic [2:0] lv, input logic [2:0] rs,
                           input logic [2:0] fl, input string tag);
    exp_t e;
    e.cyc = c;
    e.lv  = lv;
    e.rs  = rs;
    e.fl  = fl;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count strobes per channel shortly after each active edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (ifc.rise_pulse[i] === 1'b1) rise_cnt[i]++;
      if (ifc.fall_pulse[i] === 1'b1) fall_cnt[i]++;
    end
    if ((ifc.rise_pulse & ifc.fall_pulse) != 3'b000) both_err++;
  end

  // Scoreboard: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      check({e.tag, ".cycle"}, 32'(cyc), 32'(e.cyc));
      check({e.tag, ".level"}, 32'(ifc.level_out), 32'(e.lv));
      check({e.tag, ".rise"},  32'(ifc.rise_pulse), 32'(e.rs));
      check({e.tag, ".fall"},  32'(ifc.fall_pulse), 32'(e.fl));
    end
  end

  // Accept edge is 6 cycles after the falling edge on which raw_in changed.
  task automatic press(input logic [2:0] mask, input logic [2:0] old_lv, input string tag);
    int k;
    logic [2:0] new_lv;
    k = cyc;
    new_lv = old_lv | mask;
    ifc.raw_in = new_lv;
    expect_at(k + 5, old_lv, 3'b000, 3'b000, {tag, ".pre"});
    expect_at(k + 6, new_lv, mask,   3'b000, {tag, ".acc"});
    expect_at(k + 7, new_lv, 3'b000, 3'b000, {tag, ".post"});
    for (int i = 0; i < int'(WIDTH); i++) if (mask[i]) exp_rise[i]++;
  endtask

  task automatic release_ch(input logic [2:0] mask, input logic [2:0] old_lv, input string tag);
    int k;
    logic [2:0] new_lv;
    k = cyc;
    new_lv = old_lv & ~mask;
    ifc.raw_in = new_lv;
    expect_at(k + 5, old_lv, 3'b000, 3'b000, {tag, ".pre"});
    expect_at(k + 6, new_lv, 3'b000, mask,   {tag, ".acc"});
    expect_at(k + 7, new_lv, 3'b000, 3'b000, {tag, ".post"});
    for (int i = 0; i < int'(WIDTH); i++) if (mask[i]) exp_fall[i]++;
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < int'(WIDTH); i++) begin
      check($sformatf("%s.rise_cnt%0d", tag, i), 32'(rise_cnt[i]), 32'(exp_rise[i]));
      check($sformatf("%s.fall_cnt%0d", tag, i), 32'(fall_cnt[i]), 32'(exp_fall[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    total    = 0;
    bad      = 0;
    both_err = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      exp_rise[i] = 0;
      exp_fall[i] = 0;
    end

    // Reset with all inputs high: outputs stay low during reset.
    rst = 1'b1;
    ifc.raw_in = 3'b111;
    expect_at(1, 3'b000, 3'b000, 3'b000, "rst1");
    expect_at(2, 3'b000, 3'b000, 3'b000, "rst2");
    step(2);
    rst = 1'b0;
    // Reset release with raw_in=1 held behaves like a fresh press on every channel.
    k = cyc;
    expect_at(k + 5, 3'b000, 3'b000, 3'b000, "rel.pre");
    expect_at(k + 6, 3'b111, 3'b111, 3'b000, "rel.acc");
    expect_at(k + 7, 3'b111, 3'b000, 3'b000, "rel.post");
    for (int i = 0; i < int'(WIDTH); i++) exp_rise[i]++;
    step(7);
    release_ch(3'b111, 3'b111, "relall");
    step(8);
    check_counts("reset");

    // Clean press and release on channel 0.
    press(3'b001, 3'b000, "press0");
    step(8);
    release_ch(3'b001, 3'b001, "unpress0");
    step(8);
    check_counts("clean");

    // Glitch of DEBOUNCE_CYCLES-1 cycles on channel 1 is rejected.
    k = cyc;
    ifc.raw_in = 3'b010;
    expect_at(k + 6, 3'b000, 3'b000, 3'b000, "glitch.a");
    expect_at(k + 8, 3'b000, 3'b000, 3'b000, "glitch.b");
    step(3);
    ifc.raw_in = 3'b000;
    step(8);
    check_counts("glitch");

    // Bounce on channel 2 ending high: single rise after the final capture.
    ifc.raw_in = 3'b100; step(1);
    ifc.raw_in = 3'b000; step(1);
    ifc.raw_in = 3'b100; step(1);
    ifc.raw_in = 3'b000; step(1);
    k = cyc;
    expect_at(k + 3, 3'b000, 3'b000, 3'b000, "bounce.mid");
    press(3'b100, 3'b000, "bounce");
    step(8);
    check_counts("bounce");
    release_ch(3'b100, 3'b100, "unbounce");
    step(8);

    // Two channels change together and are accepted in the same cycle.
    press(3'b101, 3'b000, "par");
    step(8);
    release_ch(3'b101, 3'b101, "unpar");
    step(8);
    check_counts("parallel");

    // Reset mid-count discards the pending count on channel 0.
    k = cyc;
    ifc.raw_in = 3'b001;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_at(k + 6,  3'b000, 3'b000, 3'b000, "midrst.nominal");
    expect_at(k + 9,  3'b000, 3'b000, 3'b000, "midrst.pre");
    expect_at(k + 10, 3'b001, 3'b001, 3'b000, "midrst.acc");
    expect_at(k + 11, 3'b001, 3'b000, 3'b000, "midrst.post");
    exp_rise[0]++;
    step(9);
    check_counts("midrst");

    step(2);
    check("both_strobes", 32'(both_err), 32'd0);
    check("queue_left", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
